// File: rtl/ili934x_cmd_decoder.sv
// ILI934x write-stream command decoder: CASET/PASET window tracking and RAMWR pixel unpacking.
// Optional statistics counters are built only when ILI934X_DEC_STATS_EN is defined.
package ili934x_pkg;
    typedef struct packed {
        logic       is_cmd;
        logic [7:0] byte_pack;
    } wr_item_t;
endpackage

module ili934x_cmd_decoder
    import ili934x_pkg::*;
#(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        item_valid,
    input  wr_item_t    item,
    output logic        item_ready,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_data,
    input  logic        pix_ready,
    output logic [15:0] win_xs,
    output logic [15:0] win_xe,
    output logic [15:0] win_ys,
    output logic [15:0] win_ye,
    output logic        cmd_unknown,
    output logic [31:0] pix_count,
    output logic [15:0] drop_count
);

    localparam logic [15:0] X_MAX = 16'(H_RES - 1);
    localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

    typedef enum logic [2:0] {
        S_CMD      = 3'd0,
        S_CASET    = 3'd1,
        S_PASET    = 3'd2,
        S_RAMWR_HI = 3'd3,
        S_RAMWR_LO = 3'd4,
        S_SKIP     = 3'd5
    } state_t;

    state_t      state_r;
    logic [1:0]  arg_cnt_r;
    logic [23:0] arg_r;
    logic [7:0]  hi_r;
    logic [15:0] cur_x_r, cur_y_r;
    logic        pix_valid_r;
    logic [15:0] pix_x_r, pix_y_r, pix_data_r;
    logic [15:0] win_xs_r, win_xe_r, win_ys_r, win_ye_r;
    logic        cmd_unknown_r;

    logic        take_s;
    logic        pix_hs_s;
    logic [15:0] adv_x_s, adv_y_s;
    logic [15:0] lim_s, com_start_s, com_end_s;

    function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [15:0] order_end(input logic [15:0] s, input logic [15:0] e);
        return (e < s) ? s : e;
    endfunction

    assign take_s     = item_valid && item_ready;
    assign pix_hs_s   = pix_valid_r && pix_ready;
    assign item_ready = !(pix_valid_r && !pix_ready);

    // Cursor position after this cycle's pixel handshake (row-major, full-window wrap).
    always_comb begin
        adv_x_s = cur_x_r;
        adv_y_s = cur_y_r;
        if (pix_hs_s) begin
            if (cur_x_r == win_xe_r) begin
                adv_x_s = win_xs_r;
                if (cur_y_r == win_ye_r) begin
                    adv_y_s = win_ys_r;
                end else begin
                    adv_y_s = cur_y_r + 16'd1;
                end
            end else begin
                adv_x_s = cur_x_r + 16'd1;
                adv_y_s = cur_y_r;
            end
        end else begin
            adv_x_s = cur_x_r;
            adv_y_s = cur_y_r;
        end
    end

    // Clamped window values committed on the fourth CASET/PASET argument byte.
    always_comb begin
        lim_s = X_MAX;
        if (state_r == S_PASET) begin
            lim_s = Y_MAX;
        end else begin
            lim_s = X_MAX;
        end
        com_start_s = clamp16(arg_r[23:8], lim_s);
        com_end_s   = order_end(com_start_s, clamp16({arg_r[7:0], item.byte_pack}, lim_s));
    end

    // Main decoder FSM with registered pixel and window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_CMD;
            arg_cnt_r     <= 2'd0;
            arg_r         <= 24'd0;
            hi_r          <= 8'd0;
            cur_x_r       <= 16'd0;
            cur_y_r       <= 16'd0;
            pix_valid_r   <= 1'b0;
            pix_x_r       <= 16'd0;
            pix_y_r       <= 16'd0;
            pix_data_r    <= 16'd0;
            win_xs_r      <= 16'd0;
            win_xe_r      <= X_MAX;
            win_ys_r      <= 16'd0;
            win_ye_r      <= Y_MAX;
            cmd_unknown_r <= 1'b0;
        end else begin
            cmd_unknown_r <= 1'b0;
            cur_x_r       <= adv_x_s;
            cur_y_r       <= adv_y_s;
            if (pix_hs_s) begin
                pix_valid_r <= 1'b0;
            end
            if (take_s) begin
                if (item.is_cmd) begin
                    // A command always aborts whatever sequence was in progress.
                    arg_cnt_r <= 2'd0;
                    case (item.byte_pack)
                        8'h2A: state_r <= S_CASET;
                        8'h2B: state_r <= S_PASET;
                        8'h2C: begin
                            state_r <= S_RAMWR_HI;
                            cur_x_r <= win_xs_r;
                            cur_y_r <= win_ys_r;
                        end
                        default: begin
                            state_r       <= S_SKIP;
                            cmd_unknown_r <= 1'b1;
                        end
                    endcase
                end else begin
                    case (state_r)
                        S_CASET, S_PASET: begin
                            if (arg_cnt_r == 2'd3) begin
                                if (state_r == S_CASET) begin
                                    win_xs_r <= com_start_s;
                                    win_xe_r <= com_end_s;
                                end else begin
                                    win_ys_r <= com_start_s;
                                    win_ye_r <= com_end_s;
                                end
                                arg_cnt_r <= 2'd0;
                                state_r   <= S_CMD;
                            end else begin
                                arg_r     <= {arg_r[15:0], item.byte_pack};
                                arg_cnt_r <= arg_cnt_r + 2'd1;
                            end
                        end
                        S_RAMWR_HI: begin
                            hi_r    <= item.byte_pack;
                            state_r <= S_RAMWR_LO;
                        end
                        S_RAMWR_LO: begin
                            pix_valid_r <= 1'b1;
                            pix_data_r  <= {hi_r, item.byte_pack};
                            pix_x_r     <= adv_x_s;
                            pix_y_r     <= adv_y_s;
                            state_r     <= S_RAMWR_HI;
                        end
                        default: state_r <= state_r;
                    endcase
                end
            end
        end
    end

`ifdef ILI934X_DEC_STATS_EN
    logic [31:0] pix_count_r;
    logic [15:0] drop_count_r;
    logic        drop_s;

    assign drop_s = take_s && !item.is_cmd && ((state_r == S_CMD) || (state_r == S_SKIP));

    // Pixel handshake counter (wrapping) and dropped-data counter (saturating).
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count_r  <= 32'd0;
            drop_count_r <= 16'd0;
        end else begin
            if (pix_hs_s) begin
                pix_count_r <= pix_count_r + 32'd1;
            end
            if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign pix_count  = pix_count_r;
    assign drop_count = drop_count_r;
`else
    assign pix_count  = 32'd0;
    assign drop_count = 16'd0;
`endif

    assign pix_valid   = pix_valid_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign pix_data    = pix_data_r;
    assign win_xs      = win_xs_r;
    assign win_xe      = win_xe_r;
    assign win_ys      = win_ys_r;
    assign win_ye      = win_ye_r;
    assign cmd_unknown = cmd_unknown_r;

endmodule

// File: tb/tb_ili934x_cmd_decoder.sv
// Directed table-driven bench for ili934x_cmd_decoder plus hand-written stall/abort/reset sequences.
module tb_ili934x_cmd_decoder;
    import ili934x_pkg::*;

`ifdef ILI934X_DEC_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        item_valid = 1'b0;
    wr_item_t    item = '0;
    logic        item_ready;
    logic        pix_valid;
    logic [15:0] pix_x, pix_y, pix_data;
    logic        pix_ready = 1'b1;
    logic [15:0] win_xs, win_xe, win_ys, win_ye;
    logic        cmd_unknown;
    logic [31:0] pix_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    ili934x_cmd_decoder #(.H_RES(240), .V_RES(320)) dut (
        .clk(clk), .rst(rst), .item_valid(item_valid), .item(item), .item_ready(item_ready),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .pix_ready(pix_ready), .win_xs(win_xs), .win_xe(win_xe), .win_ys(win_ys),
        .win_ye(win_ye), .cmd_unknown(cmd_unknown), .pix_count(pix_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          c;
        logic [7:0]  b;
        bit          ep;
        logic [15:0] ex, ey, ed;
        bit          cw;
        logic [15:0] xs, xe, ys, ye;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, logic [7:0] b, bit ep = 0, logic [15:0] ex = 0,
                                logic [15:0] ey = 0, logic [15:0] ed = 0, bit cw = 0,
                                logic [15:0] xs = 0, logic [15:0] xe = 0,
                                logic [15:0] ys = 0, logic [15:0] ye = 0);
        vec_t v;
        v.c = c; v.b = b; v.ep = ep; v.ex = ex; v.ey = ey; v.ed = ed;
        v.cw = cw; v.xs = xs; v.xe = xe; v.ys = ys; v.ye = ye;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        item_valid = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one byte at a negedge, wait for it to be consumed, return at the following negedge.
    task automatic send(bit c, logic [7:0] b);
        int n = 0;
        item_valid = 1'b1;
        item.is_cmd = c;
        item.byte_pack = b;
        while (!item_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!item_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: item_ready stuck low for byte %0h", b);
        end
        @(negedge clk);
        item_valid = 1'b0;
    endtask

    task automatic check_win(string name, logic [15:0] xs, logic [15:0] xe,
                             logic [15:0] ys, logic [15:0] ye);
        chk({name, "_xs"}, 32'(win_xs), 32'(xs));
        chk({name, "_xe"}, 32'(win_xe), 32'(xe));
        chk({name, "_ys"}, 32'(win_ys), 32'(ys));
        chk({name, "_ye"}, 32'(win_ye), 32'(ye));
    endtask

    initial begin
        // Basic CASET/PASET/RAMWR stream
        tbl.push_back(mk(1, 8'h2A)); tbl.push_back(mk(0, 8'h00)); tbl.push_back(mk(0, 8'h0A));
        tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h0B, 0, 0, 0, 0, 1, 16'd10, 16'd11, 16'd0, 16'd319));
        tbl.push_back(mk(1, 8'h2B)); tbl.push_back(mk(0, 8'h00)); tbl.push_back(mk(0, 8'h14));
        tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h14, 0, 0, 0, 0, 1, 16'd10, 16'd11, 16'd20, 16'd20));
        tbl.push_back(mk(1, 8'h2C)); tbl.push_back(mk(0, 8'hF8));
        tbl.push_back(mk(0, 8'h00, 1, 16'd10, 16'd20, 16'hF800));
        tbl.push_back(mk(0, 8'h07));
        tbl.push_back(mk(0, 8'hE0, 1, 16'd11, 16'd20, 16'h07E0));
        // 2x2 window with full wrap
        tbl.push_back(mk(1, 8'h2A)); tbl.push_back(mk(0, 8'h00)); tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h00)); tbl.push_back(mk(0, 8'h01));
        tbl.push_back(mk(1, 8'h2B)); tbl.push_back(mk(0, 8'h00)); tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 1, 16'd0, 16'd1, 16'd0, 16'd1));
        tbl.push_back(mk(1, 8'h2C));
        tbl.push_back(mk(0, 8'h11)); tbl.push_back(mk(0, 8'h11, 1, 16'd0, 16'd0, 16'h1111));
        tbl.push_back(mk(0, 8'h22)); tbl.push_back(mk(0, 8'h22, 1, 16'd1, 16'd0, 16'h2222));
        tbl.push_back(mk(0, 8'h33)); tbl.push_back(mk(0, 8'h33, 1, 16'd0, 16'd1, 16'h3333));
        tbl.push_back(mk(0, 8'h44)); tbl.push_back(mk(0, 8'h44, 1, 16'd1, 16'd1, 16'h4444));
        tbl.push_back(mk(0, 8'h55)); tbl.push_back(mk(0, 8'h55, 1, 16'd0, 16'd0, 16'h5555));
        // end < start forces end = start; start beyond panel clamps
        tbl.push_back(mk(1, 8'h2A)); tbl.push_back(mk(0, 8'h00)); tbl.push_back(mk(0, 8'h64));
        tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h32, 0, 0, 0, 0, 1, 16'd100, 16'd100, 16'd0, 16'd1));
        tbl.push_back(mk(1, 8'h2B)); tbl.push_back(mk(0, 8'h02)); tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h00));
        tbl.push_back(mk(0, 8'h05, 0, 0, 0, 0, 1, 16'd100, 16'd100, 16'd319, 16'd319));

        do_reset();
        chk("rst_item_ready", 32'(item_ready), 32'd1);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_cmd_unknown", 32'(cmd_unknown), 32'd0);
        check_win("rst_win", 16'd0, 16'd239, 16'd0, 16'd319);
        chk("rst_pix_count", pix_count, 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].c, tbl[i].b);
            chk($sformatf("vec%0d_pix_valid", i), 32'(pix_valid), 32'(tbl[i].ep));
            if (tbl[i].ep) begin
                chk($sformatf("vec%0d_pix_x", i), 32'(pix_x), 32'(tbl[i].ex));
                chk($sformatf("vec%0d_pix_y", i), 32'(pix_y), 32'(tbl[i].ey));
                chk($sformatf("vec%0d_pix_data", i), 32'(pix_data), 32'(tbl[i].ed));
            end
            if (tbl[i].cw) begin
                check_win($sformatf("vec%0d_win", i), tbl[i].xs, tbl[i].xe, tbl[i].ys, tbl[i].ye);
            end
        end
        chk("tbl_pix_count", pix_count, 32'(7 * STATS));
        chk("tbl_drop_count", 32'(drop_count), 32'd0);

        // CASET aborted by PASET mid-arguments
        do_reset();
        send(1, 8'h2A); send(0, 8'h00); send(0, 8'h05); send(1, 8'h2B);
        check_win("abort_win", 16'd0, 16'd239, 16'd0, 16'd319);
        send(0, 8'h00); send(0, 8'h01); send(0, 8'h00); send(0, 8'h02);
        check_win("abort_paset", 16'd0, 16'd239, 16'd1, 16'd2);

        // Backpressure: pixel held while sink stalls, next byte waits
        do_reset();
        send(1, 8'h2C); pix_ready = 1'b0; send(0, 8'hF8); send(0, 8'h00);
        item_valid = 1'b1; item.is_cmd = 1'b0; item.byte_pack = 8'h07;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_item_ready", 32'(item_ready), 32'd0);
            chk("stall_pix_valid", 32'(pix_valid), 32'd1);
            chk("stall_pix_data", 32'(pix_data), 32'hF800);
            chk("stall_pix_xy", {pix_x, pix_y}, 32'd0);
        end
        pix_ready = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        chk("stall_release_valid", 32'(pix_valid), 32'd0);
        send(0, 8'hE0);
        chk("stall_next_valid", 32'(pix_valid), 32'd1);
        chk("stall_next_data", 32'(pix_data), 32'h07E0);
        chk("stall_next_x", 32'(pix_x), 32'd1);

        // Command consumed on the same cycle as a pixel handshake
        do_reset();
        send(1, 8'h2C); pix_ready = 1'b0; send(0, 8'hAB); send(0, 8'hCD);
        item_valid = 1'b1; item.is_cmd = 1'b1; item.byte_pack = 8'h2A;
        @(negedge clk); @(negedge clk);
        pix_ready = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        chk("same_cycle_valid", 32'(pix_valid), 32'd0);
        chk("same_cycle_count", pix_count, 32'(STATS));
        send(0, 8'h00); send(0, 8'h03); send(0, 8'h00); send(0, 8'h04);
        check_win("same_cycle_win", 16'd3, 16'd4, 16'd0, 16'd319);

        // Unknown command and dropped data
        do_reset();
        send(1, 8'h36);
        chk("unk_pulse", 32'(cmd_unknown), 32'd1);
        send(0, 8'h01);
        chk("unk_pulse_end", 32'(cmd_unknown), 32'd0);
        send(0, 8'h02); send(0, 8'h03);
        chk("unk_pix_valid", 32'(pix_valid), 32'd0);
        chk("unk_drop_count", 32'(drop_count), 32'(3 * STATS));

        // Clamp to panel edge, then abort pending high byte
        do_reset();
        send(1, 8'h2A); send(0, 8'h01); send(0, 8'h00); send(0, 8'h01); send(0, 8'h80);
        check_win("clamp_win", 16'd239, 16'd239, 16'd0, 16'd319);
        send(1, 8'h2C); send(0, 8'hF8); send(1, 8'h00);
        chk("clamp_unk", 32'(cmd_unknown), 32'd1);
        chk("clamp_no_pix", 32'(pix_valid), 32'd0);
        send(0, 8'h00);
        chk("clamp_no_pix2", 32'(pix_valid), 32'd0);
        chk("clamp_pix_count", pix_count, 32'd0);

        // Reset mid-pixel drops the pending high byte
        do_reset();
        send(1, 8'h2C); send(0, 8'hF8);
        do_reset();
        send(0, 8'h00);
        chk("rst_mid_no_pix", 32'(pix_valid), 32'd0);
        chk("rst_mid_drop", 32'(drop_count), 32'(STATS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
